instr_fetch_unit: RTL and testbench

- Program-counter and prefetch stage that sits directly upstream of the instruction memory.
- Drives the word-aligned fetch address into the combinational instruction memory and captures the returned word into a small prefetch FIFO.
- Presents {pc, instr} pairs to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump/trap) by flushing the FIFO and reloading the PC.

---
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, fetch address generation and a
// small prefetch FIFO that hands {pc, instr} pairs to decode over a
// valid/ready handshake. Redirects flush the FIFO and reload the PC.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    MEM_SIZE   = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  id_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_oob
);

  // Pointer width covers FIFO_DEPTH entries; the count needs one more bit
  // so that "full" (count == FIFO_DEPTH) is representable.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int AW1   = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);

  // Upper bound of the legal fetch range in bytes. Computed one bit wider
  // than the PC so a memory covering the whole address space cannot wrap
  // the limit to zero.
  localparam logic [AW1-1:0] MEM_LIMIT = AW1'(MEM_SIZE) << 2;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_ALIGNED =
    {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

  // Reject illegal FIFO geometries at elaboration time.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_unit: FIFO_DEPTH must be a power of two >= 2");
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0]      rd_ptr_reg,   rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg,   wr_ptr_next;
  logic [CNT_W-1:0]      count_reg,    count_next;

  // Prefetch storage. Contents need no reset: occupancy is tracked solely
  // by count_reg, and the head outputs are forced to zero when empty.
  logic [ADDR_WIDTH-1:0] pc_store    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_store [FIFO_DEPTH];

  // ------------------------------------------------------------------
  // Handshake and status decode
  // ------------------------------------------------------------------
  logic                  oob;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  assign fetch_addr      = {fetch_pc_reg[ADDR_WIDTH-1:2], 2'b00};
  assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  assign oob        = ({1'b0, fetch_pc_reg} >= MEM_LIMIT);
  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a new word while decode drains the head. A redirect squashes both.
  assign pop  = ~fifo_empty & id_ready;
  assign push = ~oob & ~redirect_valid & (~fifo_full | pop);

  assign instr_addr = fetch_addr;
  assign fetch_oob  = oob;
  assign if_valid   = ~fifo_empty;

  // Head of the FIFO presented to decode; zero while empty.
  always_comb begin
    if_pc    = '0;
    if_instr = '0;
    if (!fifo_empty) begin
      if_pc    = pc_store[rd_ptr_reg];
      if_instr = instr_store[rd_ptr_reg];
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic for PC, pointers and occupancy
  // ------------------------------------------------------------------
  // Compute next PC, pointer and count values; redirect overrides push/pop.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;

    if (redirect_valid) begin
      // Flush: whatever is at the head this cycle is squashed even if
      // decode signalled ready for it.
      fetch_pc_next = redirect_target;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_addr + ADDR_WIDTH'(4);
        wr_ptr_next   = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC_ALIGNED;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Capture the fetched word and its PC into the tail slot on each push.
  // push already excludes redirects; reset is gated so a pending write in
  // the reset cycle cannot land.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_store[wr_ptr_reg]    <= fetch_addr;
      instr_store[wr_ptr_reg] <= instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. The instruction memory model
// returns 32'h1000_0000 + word_index for every address.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_oob;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4),
    .MEM_SIZE  (512)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_addr    (instr_addr),
    .instr         (instr),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_oob     (fetch_oob)
  );

  // Combinational instruction memory model.
  assign instr = 32'h1000_0000 + {2'b00, instr_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got=%h", tag, got);
    end else begin
      $display("FAIL %-16s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_addr", instr_addr, 32'h0);
    check("rst_oob", {31'd0, fetch_oob}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // ---- Reset state and streaming with id_ready=1 ----
    do_reset();
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    rst_n    = 1'b1;
    id_ready = 1'b1;
    check("rel_valid0", {31'd0, if_valid}, 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("stream_valid", {31'd0, if_valid}, 32'd1);
      check("stream_pc", if_pc, 32'(4 * k));
      check("stream_instr", if_instr, 32'h1000_0000 + 32'(k));
      tick();
    end

    // ---- Fill with id_ready=0, then simultaneous push/pop when full ----
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("full_addr", instr_addr, 32'h10);
    check("full_head", if_pc, 32'h0);
    check("full_valid", {31'd0, if_valid}, 32'd1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("pp_addr", instr_addr, 32'h14);
    check("pp_head", if_pc, 32'h4);
    tick();
    check("hold_addr", instr_addr, 32'h14);
    check("hold_head", if_pc, 32'h4);
    id_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      check("drain_pc", if_pc, 32'(4 * k));
      check("drain_instr", if_instr, 32'h1000_0000 + 32'(k));
      tick();
    end

    // ---- Redirect with 3 entries in the FIFO ----
    do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("r3_addr", instr_addr, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    id_ready       = 1'b1;
    check("rd_cur_valid", {31'd0, if_valid}, 32'd1);
    check("rd_cur_pc", if_pc, 32'h0);
    tick();
    redirect_valid = 1'b0;
    check("rd1_valid", {31'd0, if_valid}, 32'd0);
    check("rd1_addr", instr_addr, 32'h100);
    tick();
    check("rd2_valid", {31'd0, if_valid}, 32'd1);
    check("rd2_pc", if_pc, 32'h100);
    check("rd2_instr", if_instr, 32'h1000_0040);
    tick();
    check("rd3_pc", if_pc, 32'h104);

    // ---- Back-to-back redirects: last one wins ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_pc    = 32'h301;
    tick();
    redirect_valid = 1'b0;
    check("b2b_addr", instr_addr, 32'h300);
    check("b2b_valid", {31'd0, if_valid}, 32'd0);
    tick();
    check("b2b_pc", if_pc, 32'h300);

    // ---- Out-of-range fetch halts, FIFO drains, redirect recovers ----
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7F0;
    tick();
    redirect_valid = 1'b0;
    check("pre_oob", {31'd0, fetch_oob}, 32'd0);
    for (int k = 0; k < 6; k++) tick();
    check("oob_flag", {31'd0, fetch_oob}, 32'd1);
    check("oob_addr", instr_addr, 32'h800);
    check("oob_head", if_pc, 32'h7F0);
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("oob_dvalid", {31'd0, if_valid}, 32'd1);
      check("oob_dpc", if_pc, 32'h7F0 + 32'(4 * k));
      tick();
    end
    check("oob_empty", {31'd0, if_valid}, 32'd0);
    check("oob_stay", {31'd0, fetch_oob}, 32'd1);
    tick();
    check("oob_empty2", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("rec_oob", {31'd0, fetch_oob}, 32'd0);
    check("rec_addr", instr_addr, 32'h40);
    tick();
    check("rec_valid", {31'd0, if_valid}, 32'd1);
    check("rec_pc", if_pc, 32'h40);

    // ---- Reset while full, out of range and with a redirect pending ----
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7F0;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("mid_full_oob", {31'd0, fetch_oob}, 32'd1);
    check("mid_valid", {31'd0, if_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    rst_n          = 1'b0;
    tick();
    check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    check("mid_rst_addr", instr_addr, 32'h0);
    check("mid_rst_oob", {31'd0, fetch_oob}, 32'd0);
    check("mid_rst_pc", if_pc, 32'h0);
    redirect_valid = 1'b0;
    rst_n          = 1'b1;
    id_ready       = 1'b1;
    tick();
    check("post_rst_pc", if_pc, 32'h0);
    check("post_rst_vld", {31'd0, if_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
